// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : Issue stage for ALU_reconfig. Commands (opcode, A, B) arrive on
//            a valid/ready interface and are buffered in a small FIFO. Each
//            command is presented to the ALU with a one-cycle enable. The
//            block then waits the ALU latency and captures the result into a
//            response register that has its own valid/ready handshake. Only
//            one command is in flight at a time, so results need no tags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready         command handshake (ready = FIFO not full)
//   cmd_opcode, cmd_a, cmd_b    command payload
//   alu_en, alu_a, alu_b,
//   alu_opcode                  drive the ALU inputs
//   alu_out, alu_cout,
//   alu_ouflag                  ALU result and flags
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_cout,
//   rsp_ouflag, rsp_opcode      captured result, flags and opcode echo
//   cmd_count                   FIFO occupancy
//   busy                        FSM active or FIFO non-empty
// ============================================================================
module alu_cmd_sequencer #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [OP_W-1:0]            cmd_opcode,
  input  logic [DATA_W-1:0]          cmd_a,
  input  logic [DATA_W-1:0]          cmd_b,
  output logic                       alu_en,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [OP_W-1:0]            alu_opcode,
  input  logic [2*DATA_W-1:0]        alu_out,
  input  logic                       alu_cout,
  input  logic                       alu_ouflag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2*DATA_W-1:0]        rsp_data,
  output logic                       rsp_cout,
  output logic                       rsp_ouflag,
  output logic [OP_W-1:0]            rsp_opcode,
  output logic [$clog2(DEPTH):0]     cmd_count,
  output logic                       busy
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CNT_W  = AW + 1;
  localparam int ENT_W  = OP_W + 2*DATA_W;
  localparam int WCNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [AW-1:0]     c_PTR_ONE   = AW'(1);
  localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  c_CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [WCNT_W-1:0] c_WAIT_INIT = WCNT_W'(ALU_LAT - 1);
  localparam logic [WCNT_W-1:0] c_WAIT_ONE  = WCNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  state_t           r_state;

  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_head;

  assign cmd_ready = (r_count != c_CNT_FULL);
  assign w_push    = cmd_valid && cmd_ready;
  // Pops happen only on the IDLE->ISSUE edge, so an empty FIFO is never read.
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];

  // Storage needs no reset: emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_opcode, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Issue / wait / hold sequencer
  // --------------------------------------------------------------------------
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic [OP_W-1:0]     r_shadow_op;
  logic                r_alu_en;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [OP_W-1:0]     r_alu_op;
  logic                r_rsp_valid;
  logic [2*DATA_W-1:0] r_rsp_data;
  logic                r_rsp_cout;
  logic                r_rsp_ouflag;
  logic [OP_W-1:0]     r_rsp_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_shadow_op  <= '0;
      r_alu_en     <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_ouflag <= 1'b0;
      r_rsp_op     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            // Operands stay on the ALU inputs until the next pop.
            {r_alu_op, r_alu_a, r_alu_b} <= w_head;
            r_shadow_op <= w_head[ENT_W-1 -: OP_W];
            r_alu_en    <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_alu_en   <= 1'b0;
          r_wait_cnt <= c_WAIT_INIT;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_rsp_data   <= alu_out;
            r_rsp_cout   <= alu_cout;
            r_rsp_ouflag <= alu_ouflag;
            r_rsp_op     <= r_shadow_op;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_HOLD;
          end else begin
            r_wait_cnt <= r_wait_cnt - c_WAIT_ONE;
          end
        end
        S_HOLD: begin
          // Always return through IDLE so the pop logic stays in one place.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_en     = r_alu_en;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_cout   = r_rsp_cout;
  assign rsp_ouflag = r_rsp_ouflag;
  assign rsp_opcode = r_rsp_op;
  assign cmd_count  = r_count;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Purpose  : Directed self-checking bench for alu_cmd_sequencer with a
//            one-cycle behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode = '0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic        alu_en;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_out = '0;
  logic        alu_cout = 1'b0;
  logic        alu_ouflag = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_cout;
  logic        rsp_ouflag;
  logic [3:0]  rsp_opcode;
  logic [2:0]  cmd_count;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int en_cnt = 0;
  int rsp_hi_cnt = 0;

  alu_cmd_sequencer #(
    .DATA_W (8),
    .OP_W   (4),
    .DEPTH  (4),
    .ALU_LAT(1)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_en     (alu_en),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .alu_ouflag (alu_ouflag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_cout   (rsp_cout),
    .rsp_ouflag (rsp_ouflag),
    .rsp_opcode (rsp_opcode),
    .cmd_count  (cmd_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // One-cycle ALU model: F = add, E = subtract (flags set), else {A,B}.
  always @(posedge clk) begin
    if (alu_en) begin
      case (alu_opcode)
        4'hF: begin
          alu_out    <= {7'd0, {1'b0, alu_a} + {1'b0, alu_b}};
          alu_cout   <= ({1'b0, alu_a} + {1'b0, alu_b}) > 9'h0FF;
          alu_ouflag <= 1'b0;
        end
        4'hE: begin
          alu_out    <= {8'd0, alu_a - alu_b};
          alu_cout   <= 1'b1;
          alu_ouflag <= 1'b1;
        end
        default: begin
          alu_out    <= {alu_a, alu_b};
          alu_cout   <= 1'b0;
          alu_ouflag <= 1'b0;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (alu_en)    en_cnt++;
    if (rsp_valid) rsp_hi_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single command into an idle, empty block with full timing checks.
  task automatic run_one(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] ed, input logic ec, input logic eo);
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1; rsp_ready = 1'b0;
    tick();                                   // edge E
    cmd_valid = 1'b0;
    check_eq("cnt_E", 32'(cmd_count), 32'd1);
    check_eq("en_E", 32'(alu_en), 32'd0);
    tick();                                   // E+1: ISSUE
    check_eq("en_E1", 32'(alu_en), 32'd1);
    check_eq("alu_a", 32'(alu_a), 32'(a));
    check_eq("alu_b", 32'(alu_b), 32'(b));
    check_eq("alu_op", 32'(alu_opcode), 32'(op));
    tick();                                   // E+2: WAIT
    check_eq("en_E2", 32'(alu_en), 32'd0);
    check_eq("rspv_E2", 32'(rsp_valid), 32'd0);
    tick();                                   // E+3: HOLD
    check_eq("rspv_E3", 32'(rsp_valid), 32'd1);
    check_eq("rsp_data", 32'(rsp_data), 32'(ed));
    check_eq("rsp_cout", 32'(rsp_cout), 32'(ec));
    check_eq("rsp_ouflag", 32'(rsp_ouflag), 32'(eo));
    check_eq("rsp_op", 32'(rsp_opcode), 32'(op));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("rspv_done", 32'(rsp_valid), 32'd0);
    check_eq("busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int acc;
    int en_snap;
    int rsp_snap;
    logic rdy;

    // ---------------- reset ----------------
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check_eq("rst_en", 32'(alu_en), 32'd0);
    check_eq("rst_rspv", 32'(rsp_valid), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_count", 32'(cmd_count), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_data", {8'd0, alu_a, alu_b, alu_opcode, rsp_opcode},  32'd0);
    check_eq("rst_rsp", {14'd0, rsp_data, rsp_cout, rsp_ouflag}, 32'd0);

    // ---------------- single ADD / SUB ----------------
    run_one(4'hF, 8'hAA, 8'h55, 16'h00FF, 1'b0, 1'b0);
    run_one(4'hE, 8'hAA, 8'h55, 16'h0055, 1'b1, 1'b1);

    // ---------------- fill ----------------
    acc = 0;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      cmd_opcode = 4'(acc + 1);
      cmd_a      = 8'(8'h10 + acc);
      cmd_b      = 8'(8'h01 + acc);
      rdy = cmd_ready;
      @(posedge clk);
      if (rdy) acc++;
      #1;
    end
    cmd_valid = 1'b0;
    check_eq("fill_acc", 32'(acc), 32'd5);
    check_eq("fill_ready", 32'(cmd_ready), 32'd0);
    check_eq("fill_count", 32'(cmd_count), 32'd4);

    // ---------------- backpressure ----------------
    for (int c = 0; c < 10; c++) begin
      tick();
      check_eq("bp_data", 32'(rsp_data), 32'h1001);
      check_eq("bp_en", 32'(alu_en), 32'd0);
    end
    check_eq("bp_valid", 32'(rsp_valid), 32'd1);
    check_eq("bp_op", 32'(rsp_opcode), 32'd1);
    rsp_ready = 1'b1;
    tick();                                   // edge H
    rsp_ready = 1'b0;
    check_eq("H_rspv", 32'(rsp_valid), 32'd0);
    check_eq("H_en", 32'(alu_en), 32'd0);
    tick();                                   // H+1
    check_eq("H1_en", 32'(alu_en), 32'd1);
    check_eq("H1_a", 32'(alu_a), 32'h11);
    for (int k = 1; k < 5; k++) begin
      for (int w = 0; w < 10 && !rsp_valid; w++) tick();
      check_eq("drain_valid", 32'(rsp_valid), 32'd1);
      check_eq("drain_data", 32'(rsp_data), 32'({8'(8'h10 + k), 8'(8'h01 + k)}));
      check_eq("drain_op", 32'(rsp_opcode), 32'(k + 1));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    tick();
    check_eq("drain_busy", 32'(busy), 32'd0);
    check_eq("drain_count", 32'(cmd_count), 32'd0);

    // ---------------- reset mid-op ----------------
    cmd_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cmd_opcode = 4'(c + 6);
      cmd_a      = 8'(8'h40 + c);
      cmd_b      = 8'(8'h50 + c);
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    check_eq("mo_count_pre", 32'(cmd_count), 32'd4);
    rsp_ready = 1'b1;
    tick();                                   // handshake
    rsp_ready = 1'b0;
    tick();                                   // ISSUE
    tick();                                   // WAIT
    check_eq("mo_wait_count", 32'(cmd_count), 32'd3);
    check_eq("mo_wait_rspv", 32'(rsp_valid), 32'd0);
    check_eq("mo_wait_en", 32'(alu_en), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mo_rspv", 32'(rsp_valid), 32'd0);
    check_eq("mo_count", 32'(cmd_count), 32'd0);
    check_eq("mo_ready", 32'(cmd_ready), 32'd1);
    check_eq("mo_busy", 32'(busy), 32'd0);
    check_eq("mo_alu_a", 32'(alu_a), 32'd0);
    cmd_valid = 1'b1;                         // ignored while in reset
    tick();
    tick();
    cmd_valid = 1'b0;
    check_eq("mo_push_ign", 32'(cmd_count), 32'd0);
    reset = 1'b1;
    en_snap  = en_cnt;
    rsp_snap = rsp_hi_cnt;
    repeat (10) tick();
    check_eq("mo_no_en", 32'(en_cnt), 32'(en_snap));
    check_eq("mo_no_rsp", 32'(rsp_hi_cnt), 32'(rsp_snap));
    check_eq("mo_idle", 32'(busy), 32'd0);

    // Fresh command after reset, carry out of the add.
    run_one(4'hF, 8'h01, 8'hFF, 16'h0100, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream issue stage for `ALU_reconfig`. It accepts ALU commands (opcode, A, B) over a valid/ready interface and buffers them in a small FIFO. Each command drives the ALU's `en`/`A`/`B`/`opcode` inputs for exactly one cycle, the block waits the ALU's fixed latency, and then captures `out`/`Cout_1`/`ouflag` into a response register with its own valid/ready handshake. Only one command is in flight at a time, which keeps the ALU operands stable and matches results to commands without tags.

## Interface
- `DATA_W`, default 8: operand width; result width is 2*DATA_W.
- `OP_W`, default 4: opcode width.
- `DEPTH`, default 4: command FIFO depth; must be a power of 2 and at least 2.
- `ALU_LAT`, default 1: cycles from the ALU sampling `en` to its `out` being valid; must be at least 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_opcode`  in  OP_W  ALU opcode.
- `cmd_a`, `cmd_b`  in  DATA_W  operands.
- `alu_en`  out  1  to ALU `en`.
- `alu_a`, `alu_b`  out  DATA_W  to ALU `A`/`B`.
- `alu_opcode`  out  OP_W  to ALU `opcode`.
- `alu_out`  in  2*DATA_W  from ALU `out`.
- `alu_cout`, `alu_ouflag`  in  1  from ALU `Cout_1`/`ouflag`.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_data`  out  2*DATA_W  captured result.
- `rsp_cout`, `rsp_ouflag`  out  1  captured flags.
- `rsp_opcode`  out  OP_W  opcode echo of the command that produced the response.
- `cmd_count`  out  clog2(DEPTH)+1  FIFO occupancy.
- `busy`  out  1  high when the FSM is not in IDLE or `cmd_count` is not 0.

## Operation
- FIFO:
  - Push on `cmd_valid && cmd_ready`; `cmd_ready = (cmd_count != DEPTH)`.
  - Read and write pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves `cmd_count` unchanged.
  - The FIFO never pops when empty. Pushes cannot occur when full.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if `cmd_count != 0`, go to ISSUE. On that edge, pop the head into `alu_a`/`alu_b`/`alu_opcode` and a shadow opcode register. Otherwise stay in IDLE.
  - ISSUE: lasts 1 cycle with `alu_en=1`. Then go to WAIT and load the wait counter with ALU_LAT-1.
  - WAIT: `alu_en=0`. The counter decrements each cycle. On the edge where the counter is 0, capture `alu_out`/`alu_cout`/`alu_ouflag` into the `rsp_*` registers, set `rsp_opcode` from the shadow register, set `rsp_valid=1`, and go to HOLD.
  - HOLD: on the `rsp_valid && rsp_ready` edge, clear `rsp_valid` and go to IDLE. There is never a direct HOLD→ISSUE transition.
- `alu_a`/`alu_b`/`alu_opcode` hold their values after issue until the next pop. `alu_en` is 1 only in ISSUE.
- The `rsp_*` payload is stable while `rsp_valid && !rsp_ready`.
- ALU results are passed through unmodified. The block does no arithmetic or width conversion.
- Reset (`reset=0`):
  - All outputs go to 0 immediately, except `cmd_ready`, which is 1.
  - FIFO is emptied, FSM goes to IDLE, wait counter goes to 0.
  - Pushes are ignored while reset is low.
  - Reset mid-operation discards the in-flight command and all queued commands. No response is ever produced for them.

## Timing
- Command accepted at edge E into an idle, empty block:
  - ISSUE is entered at E+1.
  - WAIT is entered at E+2.
  - `rsp_valid` rises at edge E+1+ALU_LAT+1, which is E+3 for ALU_LAT=1.
- Back-to-back throughput with `rsp_ready=1`: one command per ALU_LAT+3 cycles.
- After a response handshake at edge H, the next queued command reaches ISSUE at H+1.
- `cmd_ready` is combinational from `cmd_count`. A pop does not raise `cmd_ready` within the same cycle.

## Test plan
- Reset: hold `reset=0` for 3 cycles, then release. Require `alu_en=0`, `rsp_valid=0`, `cmd_ready=1`, `cmd_count=0`, `busy=0`, and all data outputs 0.
- Single ADD: push opcode 4'b1111 with A=8'hAA, B=8'h55, using a 1-cycle ALU model that returns 16'h00FF. Require:
  - `alu_en` high for exactly 1 cycle with `alu_a`=AA, `alu_b`=55.
  - `rsp_valid` at E+3 with `rsp_data`=16'h00FF and `rsp_opcode`=4'b1111.
- Flag pass-through: SUB 4'b1110 with A=8'hAA, B=8'h55, where the model returns 16'h0055 with `Cout_1=1` and `ouflag=1`. Require `rsp_data`=16'h0055, `rsp_cout`=1, `rsp_ouflag`=1.
- Fill: hold `cmd_valid` continuously with `rsp_ready=0`. Require exactly 5 commands accepted (1 in flight plus 4 queued), then `cmd_ready=0` and `cmd_count=4`.
- Backpressure: hold `rsp_ready=0` for 10 cycles. Require the `rsp_*` payload to stay stable and `alu_en` to stay 0. Raise `rsp_ready` for a handshake at edge H. Require the next `alu_en` pulse in the cycle after H+1, and responses in FIFO order.
- Reset mid-op: assert `reset` during WAIT with 3 commands queued. Require `rsp_valid=0` and `cmd_count=0` immediately. After release, require no response and no `alu_en` pulse until a new push.
